// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
//   Shared definitions for the shift-add multiplier datapath and its control.
//   - DATA_W_DEF : default operand width
//   - op_e       : one-hot-free operation code produced by the priority decoder
//   - decode_op  : fixed-priority decode Clr_Ld > Clr > Sub > Add > Shift
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        NOP,
        LOAD,
        CLEAR,
        SUB,
        ADD,
        SHIFT
    } op_e;

    // Exactly one operation per cycle; higher-priority requests mask lower ones.
    function automatic op_e decode_op(
        input logic clr_ld,
        input logic clr,
        input logic sub,
        input logic add,
        input logic shift
    );
        if (clr_ld)     return LOAD;
        else if (clr)   return CLEAR;
        else if (sub)   return SUB;
        else if (add)   return ADD;
        else if (shift) return SHIFT;
        else            return NOP;
    endfunction

endpackage

// File: rtl/mult_datapath_if.sv
// -----------------------------------------------------------------------------
// mult_datapath_if
//   Bundle of operation requests and register views between the multiplier
//   control (master) and the datapath (slave).
//   master : drives SW, Clr_Ld, Clr, Add, Sub, Shift; observes Aval, Bval, X, M
//   slave  : the datapath side of the same signals
// -----------------------------------------------------------------------------
interface mult_datapath_if
    import mult_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [DATA_W-1:0] SW;
    logic              Clr_Ld;
    logic              Clr;
    logic              Add;
    logic              Sub;
    logic              Shift;
    logic [DATA_W-1:0] Aval;
    logic [DATA_W-1:0] Bval;
    logic              X;
    logic              M;

    modport master (
        output SW, Clr_Ld, Clr, Add, Sub, Shift,
        input  Aval, Bval, X, M
    );

    modport slave (
        input  SW, Clr_Ld, Clr, Add, Sub, Shift,
        output Aval, Bval, X, M
    );

endinterface

// File: rtl/add_sub9.sv
// -----------------------------------------------------------------------------
// add_sub9
//   W-bit two's complement adder/subtractor (W = DATA_W+1, 9 by default).
//   a, b : operands (already sign-extended by the caller)
//   sub  : 1 -> s = a - b, 0 -> s = a + b
//   s    : W-bit result, carry-out dropped (wraps modulo 2^W)
// -----------------------------------------------------------------------------
module add_sub9 #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] s
);

    logic [W-1:0] b_eff;

    always_comb begin
        // Subtraction as a + ~b + 1, sharing the single adder.
        b_eff = sub ? ~b : b;
        s     = a + b_eff + {{(W-1){1'b0}}, sub};
    end

endmodule

// File: rtl/mult_datapath.sv
// -----------------------------------------------------------------------------
// mult_datapath
//   Register file and shifter of a signed shift-add multiplier.
//   Holds X (sign-extension bit), A (accumulator / product high half) and
//   B (multiplier / product low half). One operation per rising Clk edge,
//   chosen by fixed priority Clr_Ld > Clr > Sub > Add > Shift.
//   Ports:
//     Clk     : system clock, rising edge
//     Reset_n : asynchronous active-low reset, clears X, A, B
//     bus     : slave side of mult_datapath_if
//               SW  operand / load value, Clr_Ld/Clr/Add/Sub/Shift requests,
//               Aval/Bval/X registered views, M = B[0] combinational
// -----------------------------------------------------------------------------
module mult_datapath
    import mult_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                Clk,
    input  logic                Reset_n,
    mult_datapath_if.slave      bus
);

    logic              x_q, x_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;

    op_e               op;
    logic [DATA_W:0]   sum;

    always_comb begin
        op = decode_op(bus.Clr_Ld, bus.Clr, bus.Sub, bus.Add, bus.Shift);
    end

    // Both operands sign-extended by one bit so X receives the true sign.
    add_sub9 #(
        .W (DATA_W + 1)
    ) u_add_sub (
        .a   ({a_q[DATA_W-1], a_q}),
        .b   ({bus.SW[DATA_W-1], bus.SW}),
        .sub (op == SUB),
        .s   (sum)
    );

    always_comb begin
        x_d = x_q;
        a_d = a_q;
        b_d = b_q;
        case (op)
            LOAD: begin
                x_d = 1'b0;
                a_d = '0;
                b_d = bus.SW;
            end
            CLEAR: begin
                x_d = 1'b0;
                a_d = '0;
            end
            SUB, ADD: begin
                x_d = sum[DATA_W];
                a_d = sum[DATA_W-1:0];
            end
            SHIFT: begin
                // Arithmetic right shift of {X,A,B}: X keeps the sign.
                a_d = {x_q, a_q[DATA_W-1:1]};
                b_d = {a_q[0], b_q[DATA_W-1:1]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            x_q <= x_d;
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign bus.Aval = a_q;
    assign bus.Bval = b_q;
    assign bus.X    = x_q;
    assign bus.M    = b_q[0];

endmodule

// File: tb/tb_mult_datapath.sv
// -----------------------------------------------------------------------------
// tb_mult_datapath
//   Self-checking bench for mult_datapath. The reference model keeps X, A, B
//   as plain variables and applies each operation with integer arithmetic
//   (signed add/subtract, 17-bit arithmetic shift).
// -----------------------------------------------------------------------------
module tb_mult_datapath;

    localparam int W = 8;

    logic Clk;
    logic Reset_n;

    int checks = 0;
    int errors = 0;

    logic         m_x;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;

    mult_datapath_if #(.DATA_W(W)) bus ();

    mult_datapath #(.DATA_W(W)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected finish before 500000");
        $fatal(1, "timeout");
    end

    // Reference model: one operation on {X,A,B} by priority.
    task automatic model_step(input logic ld, input logic clr, input logic ad,
                              input logic sb, input logic sh, input logic [W-1:0] sw);
        int         sum;
        logic [W:0] r;
        logic [2*W:0] cat;
        if (ld) begin
            m_x = 1'b0; m_a = '0; m_b = sw;
        end else if (clr) begin
            m_x = 1'b0; m_a = '0;
        end else if (sb || ad) begin
            sum = int'($signed(m_a)) + (sb ? -int'($signed(sw)) : int'($signed(sw)));
            r   = sum[W:0];
            m_x = r[W];
            m_a = r[W-1:0];
        end else if (sh) begin
            cat = {m_x, m_a, m_b};
            cat = $signed(cat) >>> 1;
            m_x = cat[2*W];
            m_a = cat[2*W-1:W];
            m_b = cat[W-1:0];
        end
    endtask

    // Apply one cycle of requests, then update the model and release inputs.
    task automatic drive(input logic ld, input logic clr, input logic ad,
                         input logic sb, input logic sh, input logic [W-1:0] sw);
        bus.Clr_Ld = ld; bus.Clr = clr; bus.Add = ad; bus.Sub = sb; bus.Shift = sh;
        bus.SW = sw;
        @(posedge Clk);
        #1;
        model_step(ld, clr, ad, sb, sh, sw);
        bus.Clr_Ld = 0; bus.Clr = 0; bus.Add = 0; bus.Sub = 0; bus.Shift = 0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        bus.SW = '0; bus.Clr_Ld = 0; bus.Clr = 0; bus.Add = 0; bus.Sub = 0; bus.Shift = 0;
        m_x = 0; m_a = '0; m_b = '0;
        #2;
        checks++;
        if ({bus.X, bus.Aval, bus.Bval, bus.M} !== {1'b0, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset: got X=%0b A=%02h B=%02h M=%0b, expected all zero",
                     bus.X, bus.Aval, bus.Bval, bus.M);
        end
        @(posedge Clk);
        #2 Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        checks++;
        if ({bus.X, bus.Aval, bus.Bval} !== 17'h0) begin
            errors++;
            $display("FAIL reset_idle: got X=%0b A=%02h B=%02h, expected all zero",
                     bus.X, bus.Aval, bus.Bval);
        end
    endtask

    task automatic test_load_add_shift();
        drive(1, 0, 0, 0, 0, 8'h07);
        checks++;
        if ({bus.X, bus.Aval, bus.Bval, bus.M} !== {1'b0, 8'h00, 8'h07, 1'b1}) begin
            errors++;
            $display("FAIL load: got X=%0b A=%02h B=%02h M=%0b, expected X=0 A=00 B=07 M=1",
                     bus.X, bus.Aval, bus.Bval, bus.M);
        end
        drive(0, 0, 1, 0, 0, 8'hFD);
        checks++;
        if ({bus.X, bus.Aval, bus.Bval} !== {1'b1, 8'hFD, 8'h07}) begin
            errors++;
            $display("FAIL add_neg: got X=%0b A=%02h B=%02h, expected X=1 A=FD B=07",
                     bus.X, bus.Aval, bus.Bval);
        end
        drive(0, 0, 0, 0, 1, 8'hFD);
        checks++;
        if ({bus.X, bus.Aval, bus.Bval, bus.M} !== {1'b1, 8'hFE, 8'h83, 1'b1}) begin
            errors++;
            $display("FAIL shift: got X=%0b A=%02h B=%02h M=%0b, expected X=1 A=FE B=83 M=1",
                     bus.X, bus.Aval, bus.Bval, bus.M);
        end
        // No request: everything holds.
        drive(0, 0, 0, 0, 0, 8'h3C);
        checks++;
        if ({bus.X, bus.Aval, bus.Bval} !== {1'b1, 8'hFE, 8'h83}) begin
            errors++;
            $display("FAIL hold: got X=%0b A=%02h B=%02h, expected X=1 A=FE B=83",
                     bus.X, bus.Aval, bus.Bval);
        end
        // Clr keeps B.
        drive(0, 1, 1, 0, 1, 8'h3C);
        checks++;
        if ({bus.X, bus.Aval, bus.Bval} !== {1'b0, 8'h00, 8'h83}) begin
            errors++;
            $display("FAIL clear: got X=%0b A=%02h B=%02h, expected X=0 A=00 B=83",
                     bus.X, bus.Aval, bus.Bval);
        end
    endtask

    task automatic test_sub_priority();
        drive(1, 0, 0, 0, 0, 8'h21);
        drive(0, 0, 1, 0, 0, 8'h02);
        drive(0, 0, 1, 1, 1, 8'h03);
        checks++;
        if ({bus.X, bus.Aval, bus.Bval} !== {1'b1, 8'hFF, 8'h21}) begin
            errors++;
            $display("FAIL add_sub_prio: got X=%0b A=%02h B=%02h, expected X=1 A=FF B=21",
                     bus.X, bus.Aval, bus.Bval);
        end
        drive(1, 0, 1, 0, 0, 8'h55);
        checks++;
        if ({bus.X, bus.Aval, bus.Bval} !== {1'b0, 8'h00, 8'h55}) begin
            errors++;
            $display("FAIL load_prio: got X=%0b A=%02h B=%02h, expected X=0 A=00 B=55",
                     bus.X, bus.Aval, bus.Bval);
        end
        // 127 - (-128) = 255 fits in 9 bits: X=0, A=FF.
        drive(0, 0, 1, 0, 0, 8'h7F);
        drive(0, 0, 0, 1, 0, 8'h80);
        checks++;
        if ({bus.X, bus.Aval} !== {1'b0, 8'hFF}) begin
            errors++;
            $display("FAIL sub_minneg: got X=%0b A=%02h, expected X=0 A=FF", bus.X, bus.Aval);
        end
        // -128 - (-128) - (-128) = 128 -> 0_1000_0000
        drive(1, 0, 0, 0, 0, 8'h00);
        drive(0, 0, 1, 0, 0, 8'h80);
        drive(0, 0, 0, 1, 0, 8'h80);
        drive(0, 0, 0, 1, 0, 8'h80);
        checks++;
        if ({bus.X, bus.Aval} !== {1'b0, 8'h80}) begin
            errors++;
            $display("FAIL sub_wrap: got X=%0b A=%02h, expected X=0 A=80", bus.X, bus.Aval);
        end
    endtask

    task automatic test_random_ops();
        logic [4:0]   req;
        logic [W-1:0] sw;
        for (int unsigned i = 0; i < 300; i++) begin
            req = 5'($urandom);
            if ($urandom_range(3) == 0) req[4] = 1'b0;
            else req[4] = req[4] & req[3];
            sw  = W'($urandom);
            drive(req[4], req[3] & req[2], req[1], req[0], req[2], sw);
            checks++;
            if ({bus.X, bus.Aval, bus.Bval, bus.M} !== {m_x, m_a, m_b, m_b[0]}) begin
                errors++;
                $display("FAIL random_op %0d req=%05b sw=%02h: got X=%0b A=%02h B=%02h M=%0b, expected X=%0b A=%02h B=%02h M=%0b",
                         i, req, sw, bus.X, bus.Aval, bus.Bval, bus.M, m_x, m_a, m_b, m_b[0]);
            end
        end
    endtask

    // Bench acts as the control FSM: for each multiplier bit, add (or
    // subtract on the sign bit) when M=1, then shift.
    task automatic run_multiply(input logic [W-1:0] sw, input logic [W-1:0] bv, input string tag);
        int            p;
        logic [2*W-1:0] exp_p;
        drive(1, 0, 0, 0, 0, bv);
        for (int unsigned i = 0; i < W; i++) begin
            if (bus.M) begin
                if (i == W - 1) drive(0, 0, 0, 1, 0, sw);
                else            drive(0, 0, 1, 0, 0, sw);
            end
            drive(0, 0, 0, 0, 1, sw);
        end
        p     = int'($signed(sw)) * int'($signed(bv));
        exp_p = p[2*W-1:0];
        checks++;
        if ({bus.X, bus.Aval, bus.Bval} !== {(p < 0), exp_p}) begin
            errors++;
            $display("FAIL multiply_%s sw=%02h b=%02h: got X=%0b P=%04h, expected X=%0b P=%04h",
                     tag, sw, bv, bus.X, {bus.Aval, bus.Bval}, (p < 0), exp_p);
        end
    endtask

    task automatic test_multiply();
        run_multiply(8'hFD, 8'h07, "neg21");
        checks++;
        if ({bus.X, bus.Aval, bus.Bval} !== {1'b1, 16'hFFEB}) begin
            errors++;
            $display("FAIL multiply_const_neg21: got X=%0b P=%04h, expected X=1 P=FFEB",
                     bus.X, {bus.Aval, bus.Bval});
        end
        run_multiply(8'h80, 8'h80, "minneg");
        checks++;
        if ({bus.Aval, bus.Bval} !== 16'h4000) begin
            errors++;
            $display("FAIL multiply_const_4000: got P=%04h, expected P=4000", {bus.Aval, bus.Bval});
        end
        for (int unsigned k = 0; k < 20; k++)
            run_multiply(W'($urandom), W'($urandom), "rand");
    endtask

    task automatic test_async_reset();
        drive(1, 0, 0, 0, 0, 8'h5A);
        drive(0, 0, 1, 0, 0, 8'hB3);
        bus.Add = 1'b1;
        bus.SW  = 8'h11;
        #3 Reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.X, bus.Aval, bus.Bval, bus.M} !== 18'h0) begin
            errors++;
            $display("FAIL async_reset: got X=%0b A=%02h B=%02h M=%0b, expected all zero before edge",
                     bus.X, bus.Aval, bus.Bval, bus.M);
        end
        @(posedge Clk);
        #1;
        checks++;
        if ({bus.X, bus.Aval, bus.Bval} !== 17'h0) begin
            errors++;
            $display("FAIL reset_no_update: got X=%0b A=%02h B=%02h, expected all zero",
                     bus.X, bus.Aval, bus.Bval);
        end
        m_x = 0; m_a = '0; m_b = '0;
        #2 Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        model_step(0, 0, 1, 0, 0, 8'h11);
        bus.Add = 1'b0;
        checks++;
        if ({bus.X, bus.Aval, bus.Bval} !== {1'b0, 8'h11, 8'h00}) begin
            errors++;
            $display("FAIL reset_resume: got X=%0b A=%02h B=%02h, expected X=0 A=11 B=00",
                     bus.X, bus.Aval, bus.Bval);
        end
    endtask

    initial begin
        test_reset();
        test_load_add_shift();
        test_sub_priority();
        test_random_ops();
        test_multiply();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_datapath.md
MULT_DATAPATH -- requirements
Module: mult_datapath

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning operand width of multiplicand, accumulator and multiplier registers.
REQ-002 The block SHALL have port Clk  input  1  single system clock, all state updates on rising edge.
REQ-003 The block SHALL have port Reset_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port SW  input  DATA_W  multiplicand operand and load value for B, two's complement.
REQ-005 The block SHALL have port Clr_Ld  input  1  clear A/X and load B from SW.
REQ-006 The block SHALL have port Clr  input  1  clear A and X, hold B.
REQ-007 The block SHALL have port Add  input  1  accumulate A + SW into {X,A}.
REQ-008 The block SHALL have port Sub  input  1  accumulate A - SW into {X,A}.
REQ-009 The block SHALL have port Shift  input  1  arithmetic right shift of {X,A,B}.
REQ-010 The block SHALL have port Aval  output  DATA_W  current A register (product upper half).
REQ-011 The block SHALL have port Bval  output  DATA_W  current B register (product lower half / remaining multiplier bits).
REQ-012 The block SHALL have port X  output  1  sign-extension bit of the accumulator.
REQ-013 The block SHALL have port M  output  1  current multiplier LSB, equal to B[0], consumed by the multiplier control FSM as MX.

Function
REQ-014 The block SHALL hold three registers X (1 bit), A (DATA_W), B (DATA_W), updated only on rising Clk.
REQ-015 The block SHALL decode one operation per cycle with fixed priority Clr_Ld > Clr > Sub > Add > Shift; with no input asserted, all registers hold.
REQ-016 On Clr_Ld, the block SHALL set A=0, X=0, B=SW in the same edge.
REQ-017 On Clr, the block SHALL set A=0, X=0, leave B unchanged.
REQ-018 On Add, the block SHALL compute sign-extended (DATA_W+1)-bit sum {A[msb],A}+{SW[msb],SW}, write bit DATA_W to X and low DATA_W bits to A, carry-out discarded, B unchanged.
REQ-019 On Sub, the block SHALL compute {A[msb],A}+~{SW[msb],SW}+1 in DATA_W+1 bits, write as REQ-018; SW=most-negative value SHALL wrap modulo 2^(DATA_W+1) without flagging.
REQ-020 On Shift, the block SHALL set X unchanged, A={X,A[DATA_W-1:1]}, B={A[0],B[DATA_W-1:1]}.
REQ-021 Aval, Bval, X SHALL be direct register outputs; M SHALL be combinational B[0] with zero latency, so control sampling M sees the post-shift value one cycle after Shift.
REQ-022 Simultaneous Add and Sub SHALL perform Sub only; simultaneous Shift with any other operation SHALL perform the other operation only.
REQ-023 Each operation SHALL complete in one cycle; a full DATA_W-bit multiply under the control schedule (7 add cycles, 1 sub cycle, 8 shift cycles interleaved) SHALL leave the signed 2*DATA_W-bit product in {Aval,Bval}.

Reset
REQ-024 Assertion of Reset_n low SHALL immediately, independent of Clk, force X=0, A=0, B=0, hence M=0.
REQ-025 Reset asserted mid-multiply SHALL abandon the operation with no partial update on the next edge; deassertion SHALL resume normal decode at the first rising Clk after release.

Structure
REQ-026 DATA_W default and the operation-priority encoding (enum NOP, LOAD, CLEAR, SUB, ADD, SHIFT) SHALL live in shared package mult_pkg, imported by this block and the control FSM.
REQ-027 The (DATA_W+1)-bit adder/subtractor SHALL be a single sub-module named add_sub9 with inputs a, b, sub and output s; the register/shift logic SHALL remain in mult_datapath.

Verification
REQ-028 Load: SW=0x07, Clr_Ld one cycle -> B=0x07, A=0x00, X=0, M=1.
REQ-029 Add negative: A=0x00, SW=0xFD, Add one cycle -> X=1, A=0xFD, B unchanged.
REQ-030 Shift: X=1, A=0xFD, B=0x07, Shift -> X=1, A=0xFE, B=0x83, M=1.
REQ-031 Sub and priority: A=0x02, SW=0x03, Add and Sub together -> X=1, A=0xFF; Clr_Ld with Add -> load only.
REQ-032 Full multiply: B=0x07, SW=0xFD, driven by the control FSM schedule -> {Aval,Bval}=0xFFEB (-21), X=1; repeat SW=0x80, B=0x80 -> 0x4000.
REQ-033 Async reset: drop Reset_n between edges during Add cycle -> A, B, X zero before next edge; no update on that edge.
